if_id_hazard_ctrl: RTL and testbench

- Pipeline control unit that sequences the IF/ID pipeline register and the PC.
- Detects load-use hazards, multi-cycle multiply occupancy in ID, ID-resolved jumps and EX-resolved taken branches.
- Generates PC write-enable, IF/ID write-enable and flush, the ID/EX bubble, and the PC source select.
- Sits beside the IF/ID register and the hazard-facing ports of ID/EX; keeps a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/if_id_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/if_id_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the IF/ID hazard control unit.
package hazard_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline control: load-use and multiply stalls, jump/branch redirect,
// IF/ID flush, ID/EX bubble, and a saturating stall-cycle counter.
module if_id_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_idex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_idex_rt,
  input  logic                  i_id_jump,
  input  logic                  i_id_mul_start,
  input  logic                  i_ex_branch_taken,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_bubble,
  output logic [1:0]            o_pc_src,
  output logic                  o_mul_busy,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  localparam int MCW = $clog2(MUL_LATENCY + 1);

  state_t         r_state, w_state_next;
  logic [MCW-1:0] r_mul_cnt, w_mul_cnt_next;
  logic           r_mul_granted, w_mul_granted_next;
  logic           w_lu;
  logic           w_mul_req;

  assign w_lu = i_idex_mem_read && (i_idex_rt != '0) &&
                ((i_idex_rt == i_id_rs) || (i_id_uses_rt && (i_idex_rt == i_id_rt)));
  assign w_mul_req = (r_state == RUN) && i_id_mul_start && !r_mul_granted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_mul_cnt     <= '0;
      r_mul_granted <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_mul_cnt     <= w_mul_cnt_next;
      r_mul_granted <= w_mul_granted_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_mul_cnt_next     = r_mul_cnt;
    w_mul_granted_next = r_mul_granted;
    if (i_ex_branch_taken) begin
      w_state_next       = RUN;
      w_mul_cnt_next     = '0;
      w_mul_granted_next = 1'b0;
    end else if (r_state == MUL_WAIT) begin
      if (r_mul_cnt == '0) begin
        w_state_next       = RUN;
        w_mul_granted_next = 1'b1;
      end else begin
        w_mul_cnt_next = r_mul_cnt - MCW'(1);
      end
    end else if (w_lu) begin
      // Load-use stall keeps any grant so the multiply still advances afterwards.
      w_mul_granted_next = r_mul_granted;
    end else if (w_mul_req) begin
      w_state_next   = MUL_WAIT;
      w_mul_cnt_next = MCW'(MUL_LATENCY - 1);
    end else begin
      w_mul_granted_next = 1'b0;
    end
  end

  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pc_src       = PCSRC_SEQ;
    o_mul_busy     = (r_state == MUL_WAIT);
    if (!reset) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      o_mul_busy     = 1'b0;
    end else if (i_ex_branch_taken) begin
      o_pc_src       = PCSRC_BRANCH;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if ((r_state == MUL_WAIT) || w_lu || w_mul_req) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_id_jump) begin
      o_pc_src      = PCSRC_JUMP;
      o_if_id_flush = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (!o_pc_write),
    .o_count (o_stall_cycles)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl: directed hazard scenarios then random traffic.
module tb_if_id_hazard_ctrl;

  localparam int RW  = 5;
  localparam int ML  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct {
    bit        rst_n;
    bit [RW-1:0] rs;
    bit [RW-1:0] rt;
    bit        uses_rt;
    bit        mem_read;
    bit [RW-1:0] idex_rt;
    bit        jump;
    bit        mul;
    bit        br;
  } in_t;

  typedef struct {
    bit       pcw;
    bit       ifw;
    bit       fl;
    bit       bub;
    bit [1:0] src;
    bit       busy;
    int       stalls;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic          id_uses_rt = 1'b0, idex_mem_read = 1'b0, id_jump = 1'b0;
  logic          id_mul_start = 1'b0, ex_branch_taken = 1'b0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, mul_busy;
  logic [1:0]    pc_src;
  logic [CW-1:0] stall_cycles;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model: remaining multiply-wait cycles, grant flag, stall total.
  int m_mul_left = 0;
  bit m_granted  = 1'b0;
  int m_stalls   = 0;

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(.REG_ADDR_W(RW), .MUL_LATENCY(ML), .CNT_W(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rt      (id_uses_rt),
    .i_idex_mem_read   (idex_mem_read),
    .i_idex_rt         (idex_rt),
    .i_id_jump         (id_jump),
    .i_id_mul_start    (id_mul_start),
    .i_ex_branch_taken (ex_branch_taken),
    .o_pc_write        (pc_write),
    .o_if_id_write     (if_id_write),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_bubble    (id_ex_bubble),
    .o_pc_src          (pc_src),
    .o_mul_busy        (mul_busy),
    .o_stall_cycles    (stall_cycles)
  );

  function automatic exp_t model(input in_t x);
    exp_t e;
    bit   lu;
    e.stalls = m_stalls;
    e.busy   = (m_mul_left > 0);
    e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.src = 2'd0;
    if (!x.rst_n) begin
      e.pcw = 0; e.ifw = 0; e.fl = 1; e.bub = 1; e.busy = 0; e.stalls = 0;
      m_mul_left = 0; m_granted = 0; m_stalls = 0;
      return e;
    end
    lu = x.mem_read && (x.idex_rt != 0) &&
         ((x.idex_rt == x.rs) || (x.uses_rt && (x.idex_rt == x.rt)));
    if (x.br) begin
      e.src = 2'd2; e.fl = 1; e.bub = 1;
      m_mul_left = 0; m_granted = 0;
    end else if (m_mul_left > 0) begin
      e.pcw = 0; e.ifw = 0; e.bub = 1;
      m_mul_left--;
      if (m_mul_left == 0) m_granted = 1;
    end else if (lu) begin
      e.pcw = 0; e.ifw = 0; e.bub = 1;
    end else if (x.mul && !m_granted) begin
      e.pcw = 0; e.ifw = 0; e.bub = 1;
      m_mul_left = ML;
    end else if (x.jump) begin
      e.src = 2'd1; e.fl = 1;
      m_granted = 0;
    end else begin
      m_granted = 0;
    end
    if (!e.pcw && m_stalls < SAT) m_stalls++;
    return e;
  endfunction

  task automatic apply(input in_t x);
    @(posedge clk);
    #2;
    reset           = x.rst_n;
    id_rs           = x.rs;
    id_rt           = x.rt;
    id_uses_rt      = x.uses_rt;
    idex_mem_read   = x.mem_read;
    idex_rt         = x.idex_rt;
    id_jump         = x.jump;
    id_mul_start    = x.mul;
    ex_branch_taken = x.br;
    sb.push_back(model(x));
  endtask

  function automatic in_t idle();
    in_t x;
    x = '{rst_n: 1'b1, rs: '0, rt: '0, uses_rt: 1'b0, mem_read: 1'b0,
          idex_rt: '0, jump: 1'b0, mul: 1'b0, br: 1'b0};
    return x;
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endfunction

  // Monitor: outputs are combinational, so every driven cycle yields one response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_write",     int'(pc_write),     int'(e.pcw));
        chk("if_id_write",  int'(if_id_write),  int'(e.ifw));
        chk("if_id_flush",  int'(if_id_flush),  int'(e.fl));
        chk("id_ex_bubble", int'(id_ex_bubble), int'(e.bub));
        chk("pc_src",       int'(pc_src),       int'(e.src));
        chk("mul_busy",     int'(mul_busy),     int'(e.busy));
        chk("stall_cycles", int'(stall_cycles), e.stalls);
        $display("txn t=%0t pcw=%0b ifw=%0b fl=%0b bub=%0b src=%0d busy=%0b stalls=%0d",
                 $time, pc_write, if_id_write, if_id_flush, id_ex_bubble, pc_src,
                 mul_busy, stall_cycles);
      end
    end
  end

  initial begin
    in_t x;
    // Reset for two cycles, then quiet.
    x = idle(); x.rst_n = 0;
    repeat (2) apply(x);
    repeat (2) apply(idle());
    // Single load-use, then the same with a zero destination.
    x = idle(); x.mem_read = 1; x.idex_rt = 5; x.rs = 5;
    apply(x);
    apply(idle());
    x.idex_rt = 0; x.rs = 0;
    apply(x);
    apply(idle());
    // Multiply held in ID: five stalls then advance without re-entry.
    x = idle(); x.rst_n = 0; apply(x);
    x = idle(); x.mul = 1;
    repeat (7) apply(x);
    apply(idle());
    // Branch aborts the multiply on its second wait cycle.
    x = idle(); x.rst_n = 0; apply(x);
    x = idle(); x.mul = 1;
    repeat (2) apply(x);
    x.br = 1; apply(x);
    repeat (2) apply(idle());
    // Jump held off by a load-use, then taken.
    x = idle(); x.jump = 1; x.mem_read = 1; x.idex_rt = 7; x.rt = 7; x.uses_rt = 1;
    apply(x);
    x = idle(); x.jump = 1;
    apply(x);
    apply(idle());
    // Saturation: 2^CNT_W+3 consecutive stalls.
    x = idle(); x.rst_n = 0; apply(x);
    x = idle(); x.mem_read = 1; x.idex_rt = 3; x.rs = 3;
    repeat ((1 << CW) + 3) apply(x);
    apply(idle());
    // Reset during a multiply wait.
    x = idle(); x.mul = 1;
    repeat (2) apply(x);
    x.rst_n = 0; apply(x);
    repeat (2) apply(idle());
    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      x.rst_n    = ($urandom_range(0, 99) >= 2);
      x.rs       = RW'($urandom_range(0, 3));
      x.rt       = RW'($urandom_range(0, 3));
      x.uses_rt  = $urandom_range(0, 1) == 1;
      x.mem_read = ($urandom_range(0, 99) < 30);
      x.idex_rt  = RW'($urandom_range(0, 3));
      x.jump     = ($urandom_range(0, 99) < 20);
      x.mul      = ($urandom_range(0, 99) < 15);
      x.br       = ($urandom_range(0, 99) < 8);
      apply(x);
    end
    apply(idle());
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
